// File: rtl/lab_sched_pkg.sv
// Shared types and constants for the LAB readout event sequencer and the
// per-LAB readout controllers it drives.
package lab_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_READY  = 3'd4
  } sched_state_e;

  localparam int LAB_SEL_W    = 4;
  localparam int NUM_LABS_DEF = 12;
  // Clocks a LAB controller needs for one full counter-based readout.
  localparam int COUNT_MAX    = 2340;

endpackage

// File: rtl/lab_readout_sched_if.sv
// Trigger, LAB-bank and event-handshake signals of the readout sequencer.
// master = sequencer side, slave = LAB bank / trigger / buffer side.
interface lab_readout_sched_if
  import lab_sched_pkg::*;
#(
  parameter int NUM_LABS = NUM_LABS_DEF,
  parameter int EVNUM_W  = 16
) ();

  logic                 trig_i;
  logic [NUM_LABS-1:0]  lab_en_i;
  logic                 hold_o;
  logic [NUM_LABS-1:0]  readout_o;
  logic [NUM_LABS-1:0]  done_i;
  logic [LAB_SEL_W-1:0] lab_sel_o;
  logic                 busy_o;
  logic                 event_valid_o;
  logic                 event_ack_i;
  logic [EVNUM_W-1:0]   event_num_o;
  logic                 trig_lost_o;
  logic                 timeout_o;
  logic                 err_clr_i;

  modport master (
    input  trig_i, lab_en_i, done_i, event_ack_i, err_clr_i,
    output hold_o, readout_o, lab_sel_o, busy_o, event_valid_o,
           event_num_o, trig_lost_o, timeout_o
  );

  modport slave (
    output trig_i, lab_en_i, done_i, event_ack_i, err_clr_i,
    input  hold_o, readout_o, lab_sel_o, busy_o, event_valid_o,
           event_num_o, trig_lost_o, timeout_o
  );

endinterface

// File: rtl/lab_next_sel.sv
// Lowest-set-bit priority encoder: picks the next LAB to read from the
// remaining mask.
module lab_next_sel
  import lab_sched_pkg::*;
#(
  parameter int NUM_LABS = NUM_LABS_DEF
) (
  input  logic [NUM_LABS-1:0]  mask_i,
  output logic [LAB_SEL_W-1:0] idx_o,
  output logic                 any_o
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_o = {LAB_SEL_W{1'b0}};
    any_o = 1'b0;
    for (int i = NUM_LABS - 1; i >= 0; i--) begin
      idx_o = mask_i[i] ? LAB_SEL_W'(i) : idx_o;
      any_o = any_o | mask_i[i];
    end
  end

endmodule

// File: rtl/lab_readout_sched.sv
// Event-level sequencer: on trigger holds every LAB, reads the enabled LABs
// one by one (start pulse / wait for done), then offers the event downstream.
module lab_readout_sched
  import lab_sched_pkg::*;
#(
  parameter int NUM_LABS       = NUM_LABS_DEF,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int EVNUM_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  lab_readout_sched_if.master bus
);

  // One down-counter serves both the settle delay and the per-LAB timeout.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_e         state_q, state_d;
  logic [NUM_LABS-1:0]  rem_q, rem_d;
  logic [NUM_LABS-1:0]  cur_q, cur_d;
  logic [NUM_LABS-1:0]  readout_q, readout_d;
  logic [LAB_SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EVNUM_W-1:0]   evnum_q, evnum_d;
  logic                 hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 lost_q, lost_d;
  logic                 tmo_q, tmo_d;
  logic                 trig_prev_q;

  logic [LAB_SEL_W-1:0] nxt_idx_s;
  logic                 nxt_any_s;
  logic [NUM_LABS-1:0]  nxt_oh_s;
  logic                 done_s;
  logic                 expire_s;

  lab_next_sel #(.NUM_LABS(NUM_LABS)) u_next_sel (
    .mask_i (rem_q),
    .idx_o  (nxt_idx_s),
    .any_o  (nxt_any_s)
  );

  assign nxt_oh_s = NUM_LABS'(1'b1) << nxt_idx_s;
  // Only the LAB currently being read may end the wait.
  assign done_s   = |(bus.done_i & cur_q);
  assign expire_s = (cnt_q == {CNT_W{1'b0}});

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cur_d   = cur_q;
    sel_d   = sel_q;
    evnum_d = evnum_q;
    valid_d = 1'b0;
    tmo_d   = bus.err_clr_i ? 1'b0 : tmo_q;
    cnt_d   = expire_s ? cnt_q : cnt_q - CNT_W'(1'b1);

    case (state_q)
      ST_IDLE: begin
        if (bus.trig_i) begin
          state_d = ST_SETTLE;
          rem_d   = bus.lab_en_i;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (expire_s) begin
          state_d = nxt_any_s ? ST_ISSUE : ST_READY;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_s || expire_s) begin
          state_d = nxt_any_s ? ST_ISSUE : ST_READY;
          // A done arriving on the expiry cycle still counts as on time.
          tmo_d   = tmo_d | ~done_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_READY: begin
        if (valid_q && bus.event_ack_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          evnum_d = evnum_q + EVNUM_W'(1'b1);
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_ISSUE) begin
      sel_d     = nxt_idx_s;
      cur_d     = nxt_oh_s;
      rem_d     = rem_q & ~nxt_oh_s;
      cnt_d     = CNT_W'(TIMEOUT_CYCLES - 1);
      readout_d = nxt_oh_s;
    end else begin
      readout_d = {NUM_LABS{1'b0}};
    end

    hold_d = (state_d == ST_SETTLE) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    busy_d = (state_d != ST_IDLE);
    lost_d = bus.trig_i && !trig_prev_q && (state_q != ST_IDLE);
  end

  // State and output registers; reset drops hold/readout at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      rem_q       <= {NUM_LABS{1'b0}};
      cur_q       <= {NUM_LABS{1'b0}};
      readout_q   <= {NUM_LABS{1'b0}};
      sel_q       <= {LAB_SEL_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      evnum_q     <= {EVNUM_W{1'b0}};
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
      tmo_q       <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cur_q       <= cur_d;
      readout_q   <= readout_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      evnum_q     <= evnum_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
      tmo_q       <= tmo_d;
      trig_prev_q <= bus.trig_i;
    end
  end

  assign bus.hold_o        = hold_q;
  assign bus.readout_o     = readout_q;
  assign bus.lab_sel_o     = sel_q;
  assign bus.busy_o        = busy_q;
  assign bus.event_valid_o = valid_q;
  assign bus.event_num_o   = evnum_q;
  assign bus.trig_lost_o   = lost_q;
  assign bus.timeout_o     = tmo_q;

endmodule
